// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage.
// Holds the MemOp encodings, FSM state type, default bus timeout,
// byte-enable constants and small op-decode helpers.
package mem_pkg;

  // MemOp encodings; any unlisted code behaves as OpNone.
  localparam logic [2:0] OpNone = 3'b000;
  localparam logic [2:0] OpLw   = 3'b001;
  localparam logic [2:0] OpLbu  = 3'b010;
  localparam logic [2:0] OpLb   = 3'b011;
  localparam logic [2:0] OpSw   = 3'b100;
  localparam logic [2:0] OpSb   = 3'b101;

  localparam int unsigned DefaultTimeout = 15;

  localparam logic [3:0] BeNone  = 4'b0000;
  localparam logic [3:0] BeByte0 = 4'b0001;
  localparam logic [3:0] BeWord  = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StFinish
  } memState_e;

  function automatic logic isLoad(input logic [2:0] op);
    return (op == OpLw) || (op == OpLbu) || (op == OpLb);
  endfunction

  function automatic logic isStore(input logic [2:0] op);
    return (op == OpSw) || (op == OpSb);
  endfunction

  function automatic logic isWordOp(input logic [2:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

  function automatic logic isValidOp(input logic [2:0] op);
    return isLoad(op) || isStore(op);
  endfunction

  // Word ops enable all lanes; byte ops enable the lane picked by the low address bits.
  function automatic logic [3:0] byteEnable(input logic [2:0] op, input logic [1:0] lsb);
    if (isWordOp(op)) return BeWord;
    if (isValidOp(op)) return BeByte0 << lsb;
    return BeNone;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the addressed byte of a read word (little-endian)
// and sign- or zero-extends it; word loads pass straight through.
//   rData    in  32  raw memory read word
//   byteSel  in  2   byte offset within the word
//   op       in  3   MemOp of the access
//   loadData out 32  aligned, extended result
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rData,
  input  logic [1:0]  byteSel,
  input  logic [2:0]  op,
  output logic [31:0] loadData
);

  logic [7:0] selByte;

  always_comb begin
    selByte = rData[7:0];
    unique case (byteSel)
      2'd0: selByte = rData[7:0];
      2'd1: selByte = rData[15:8];
      2'd2: selByte = rData[23:16];
      2'd3: selByte = rData[31:24];
    endcase
  end

  always_comb begin
    loadData = rData;
    case (op)
      OpLb:    loadData = {{24{selByte[7]}}, selByte};
      OpLbu:   loadData = {24'h000000, selByte};
      default: loadData = rData;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage. Latches an ALU byte address and store operand on
// Start, checks alignment/range, then runs one request/ack transaction on the
// memory port with a timeout. Busy stalls the core while an access is
// outstanding; Done pulses for one cycle with LoadData/AddrErr valid.
//   clk, rst_n           clock, synchronous active-low reset
//   Start, MemOp         access request and operation (sampled only when idle)
//   Addr, StoreData      byte address and store operand
//   Busy, Done           stall flag and completion pulse
//   LoadData, AddrErr    load result and fault flag (held between Done pulses)
//   MemReq..MemBe        memory request port
//   MemRData, MemAck     memory response
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [2:0]        MemOp,
  input  logic [31:0]       Addr,
  input  logic [31:0]       StoreData,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       LoadData,
  output logic              AddrErr,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic [3:0]        MemBe,
  input  logic [31:0]       MemRData,
  input  logic              MemAck
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  memState_e         stateQ, stateD;
  logic [2:0]        opQ, opD;
  logic [ADDR_W+1:0] addrQ, addrD;
  logic [31:0]       storeQ, storeD;
  logic [CntW-1:0]   cntQ, cntD;
  logic              errQ, errD;
  logic [31:0]       loadQ, loadD;

  logic [31:0] alignedData;
  logic        startFault;

  mem_load_align uLoadAlign (
    .rData    (MemRData),
    .byteSel  (addrQ[1:0]),
    .op       (opQ),
    .loadData (alignedData)
  );

  // Misaligned word access, or any address bit beyond the memory size.
  assign startFault = (isWordOp(MemOp) && (Addr[1:0] != 2'b00)) ||
                      (|Addr[31:ADDR_W+2]);

  always_comb begin
    stateD = stateQ;
    opD    = opQ;
    addrD  = addrQ;
    storeD = storeQ;
    cntD   = cntQ;
    errD   = errQ;
    loadD  = loadQ;
    case (stateQ)
      StIdle: begin
        if (Start) begin
          opD    = MemOp;
          addrD  = Addr[ADDR_W+1:0];
          storeD = StoreData;
          cntD   = '0;
          if (!isValidOp(MemOp)) begin
            stateD = StFinish;
            errD   = 1'b0;
          end else if (startFault) begin
            stateD = StFinish;
            errD   = 1'b1;
          end else begin
            stateD = StAccess;
          end
        end
      end
      StAccess: begin
        // An ack in the final allowed cycle still completes normally.
        if (MemAck) begin
          stateD = StFinish;
          errD   = 1'b0;
          if (isLoad(opQ)) loadD = alignedData;
        end else if (cntQ == CntLast) begin
          stateD = StFinish;
          errD   = 1'b1;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StFinish: stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      opQ    <= OpNone;
      addrQ  <= '0;
      storeQ <= '0;
      cntQ   <= '0;
      errQ   <= 1'b0;
      loadQ  <= '0;
    end else begin
      stateQ <= stateD;
      opQ    <= opD;
      addrQ  <= addrD;
      storeQ <= storeD;
      cntQ   <= cntD;
      errQ   <= errD;
      loadQ  <= loadD;
    end
  end

  // Every output decodes only flopped state; memory response never reaches outputs directly.
  always_comb begin
    Busy     = (stateQ != StIdle);
    Done     = (stateQ == StFinish);
    MemReq   = (stateQ == StAccess);
    LoadData = loadQ;
    AddrErr  = errQ;
    MemAddr  = addrQ[ADDR_W+1:2];
    MemWe    = 1'b0;
    MemBe    = BeNone;
    MemWData = '0;
    if (stateQ == StAccess) begin
      MemWe = isStore(opQ);
      MemBe = byteEnable(opQ, addrQ[1:0]);
      if (opQ == OpSb)      MemWData = {4{storeQ[7:0]}};
      else if (opQ == OpSw) MemWData = storeQ;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadData;
  logic        AddrErr;
  logic        MemReq;
  logic        MemWe;
  logic [9:0]  MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBe;
  logic [31:0] MemRData;
  logic        MemAck;

  int nCompared = 0;
  int nMismatched = 0;

  mem_access #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .MemOp     (MemOp),
    .Addr      (Addr),
    .StoreData (StoreData),
    .Busy      (Busy),
    .Done      (Done),
    .LoadData  (LoadData),
    .AddrErr   (AddrErr),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemBe     (MemBe),
    .MemRData  (MemRData),
    .MemAck    (MemAck)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are then driven and outputs sampled 1 ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd);
    Start = 1'b1;
    MemOp = op;
    Addr = a;
    StoreData = sd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    nCompared++;
    if ({Busy, Done, MemReq, MemWe, AddrErr} !== 5'b0) begin
      nMismatched++;
      $display("FAIL reset_flags: got %b expected 00000", {Busy, Done, MemReq, MemWe, AddrErr});
    end
    nCompared++;
    if (LoadData !== 32'h0) begin
      nMismatched++;
      $display("FAIL reset_load: got %h expected 00000000", LoadData);
    end
    nCompared++;
    if ({MemAddr, MemBe, MemWData} !== 46'h0) begin
      nMismatched++;
      $display("FAIL reset_bus: got %h/%b/%h expected 0", MemAddr, MemBe, MemWData);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    startOp(3'b001, 32'h0000_0010, 32'h0);
    MemRData = 32'hDEAD_BEEF;
    step();  // cycle 1
    Start = 1'b0;
    nCompared++;
    if ({MemReq, MemWe, Busy, Done} !== 4'b1010) begin
      nMismatched++;
      $display("FAIL lw_req: got %b expected 1010", {MemReq, MemWe, Busy, Done});
    end
    nCompared++;
    if (MemAddr !== 10'd4 || MemBe !== 4'b1111) begin
      nMismatched++;
      $display("FAIL lw_addr_be: got %0d/%b expected 4/1111", MemAddr, MemBe);
    end
    MemAck = 1'b1;
    step();  // cycle 2
    MemAck = 1'b0;
    nCompared++;
    if ({Done, Busy, MemReq, AddrErr} !== 4'b1100) begin
      nMismatched++;
      $display("FAIL lw_done: got %b expected 1100", {Done, Busy, MemReq, AddrErr});
    end
    nCompared++;
    if (LoadData !== 32'hDEAD_BEEF) begin
      nMismatched++;
      $display("FAIL lw_data: got %h expected deadbeef", LoadData);
    end
    step();  // cycle 3
    nCompared++;
    if ({Done, Busy} !== 2'b00) begin
      nMismatched++;
      $display("FAIL lw_idle: got %b expected 00", {Done, Busy});
    end
  endtask

  task automatic test_byte_load(input logic [2:0] op, input logic [31:0] expData);
    startOp(op, 32'h0000_0013, 32'h0);
    MemRData = 32'h0000_0000;
    step();  // cycle 1
    Start = 1'b0;
    nCompared++;
    if (MemReq !== 1'b1 || MemAddr !== 10'd4 || MemBe !== 4'b1000) begin
      nMismatched++;
      $display("FAIL byte_req: got %b/%0d/%b expected 1/4/1000", MemReq, MemAddr, MemBe);
    end
    step();  // cycle 2
    step();  // cycle 3
    nCompared++;
    if ({MemReq, Done} !== 2'b10) begin
      nMismatched++;
      $display("FAIL byte_wait: got %b expected 10", {MemReq, Done});
    end
    MemRData = 32'h80FF_1234;
    MemAck = 1'b1;
    step();  // cycle 4
    MemAck = 1'b0;
    MemRData = 32'h0;
    nCompared++;
    if ({Done, MemReq, AddrErr} !== 3'b100) begin
      nMismatched++;
      $display("FAIL byte_done: got %b expected 100", {Done, MemReq, AddrErr});
    end
    nCompared++;
    if (LoadData !== expData) begin
      nMismatched++;
      $display("FAIL byte_data op%0d: got %h expected %h", op, LoadData, expData);
    end
    step();
  endtask

  task automatic test_sb();
    startOp(3'b101, 32'h0000_0006, 32'h0000_00A5);
    step();  // cycle 1
    Start = 1'b0;
    nCompared++;
    if ({MemReq, MemWe} !== 2'b11 || MemBe !== 4'b0100 || MemAddr !== 10'd1) begin
      nMismatched++;
      $display("FAIL sb_req: got %b/%b/%0d expected 11/0100/1", {MemReq, MemWe}, MemBe, MemAddr);
    end
    nCompared++;
    if (MemWData !== 32'hA5A5_A5A5) begin
      nMismatched++;
      $display("FAIL sb_wdata: got %h expected a5a5a5a5", MemWData);
    end
    MemAck = 1'b1;
    step();  // cycle 2
    MemAck = 1'b0;
    nCompared++;
    if ({Done, AddrErr} !== 2'b10 || LoadData !== 32'h0000_0080) begin
      nMismatched++;
      $display("FAIL sb_done: got %b/%h expected 10/00000080", {Done, AddrErr}, LoadData);
    end
    step();
  endtask

  task automatic test_back_to_back();
    startOp(3'b100, 32'h0000_0008, 32'h1234_5678);
    step();  // cycle 1
    Start = 1'b0;
    nCompared++;
    if (MemWData !== 32'h1234_5678 || MemBe !== 4'b1111 || MemAddr !== 10'd2 || MemWe !== 1'b1) begin
      nMismatched++;
      $display("FAIL sw_req: got %h/%b/%0d/%b expected 12345678/1111/2/1",
               MemWData, MemBe, MemAddr, MemWe);
    end
    MemAck = 1'b1;
    step();  // cycle 2: Done; a Start here must be ignored
    MemAck = 1'b0;
    startOp(3'b001, 32'h0000_0020, 32'h0);
    MemRData = 32'h0BAD_F00D;
    nCompared++;
    if (Done !== 1'b1) begin
      nMismatched++;
      $display("FAIL b2b_done: got %b expected 1", Done);
    end
    step();  // cycle 3: idle, Start still high and now accepted
    nCompared++;
    if ({Busy, MemReq} !== 2'b00) begin
      nMismatched++;
      $display("FAIL b2b_ignored: got %b expected 00", {Busy, MemReq});
    end
    step();  // cycle 4
    Start = 1'b0;
    nCompared++;
    if (MemReq !== 1'b1 || MemAddr !== 10'd8) begin
      nMismatched++;
      $display("FAIL b2b_req: got %b/%0d expected 1/8", MemReq, MemAddr);
    end
    MemAck = 1'b1;
    step();  // cycle 5
    MemAck = 1'b0;
    nCompared++;
    if (Done !== 1'b1 || LoadData !== 32'h0BAD_F00D) begin
      nMismatched++;
      $display("FAIL b2b_data: got %b/%h expected 1/0badf00d", Done, LoadData);
    end
    step();
  endtask

  task automatic test_faults();
    logic [2:0]  ops [4];
    logic [31:0] addrs [4];
    logic        errs [4];
    ops[0] = 3'b001; addrs[0] = 32'h0000_0002; errs[0] = 1'b1;  // misaligned lw
    ops[1] = 3'b100; addrs[1] = 32'h0000_1000; errs[1] = 1'b1;  // out of range sw
    ops[2] = 3'b000; addrs[2] = 32'h0000_1001; errs[2] = 1'b0;  // none
    ops[3] = 3'b110; addrs[3] = 32'h0000_0004; errs[3] = 1'b0;  // reserved code acts as none
    for (int i = 0; i < 4; i++) begin
      startOp(ops[i], addrs[i], 32'hFFFF_FFFF);
      step();  // cycle 1
      Start = 1'b0;
      nCompared++;
      if ({MemReq, Done, Busy, AddrErr} !== {3'b011, errs[i]}) begin
        nMismatched++;
        $display("FAIL fault_%0d: got %b expected %b", i, {MemReq, Done, Busy, AddrErr},
                 {3'b011, errs[i]});
      end
      step();  // cycle 2
      nCompared++;
      if ({Done, Busy, AddrErr} !== {2'b00, errs[i]} || LoadData !== 32'h0BAD_F00D) begin
        nMismatched++;
        $display("FAIL fault_hold_%0d: got %b/%h expected %b/0badf00d", i, {Done, Busy, AddrErr},
                 LoadData, {2'b00, errs[i]});
      end
    end
  endtask

  task automatic test_timeout();
    int reqCycles = 0;
    startOp(3'b001, 32'h0000_0040, 32'h0);
    MemRData = 32'h5555_5555;
    step();  // cycle 1
    for (int c = 1; c <= 15; c++) begin
      // Stray Start pulses while busy must not relatch anything.
      if (c % 3 == 0) startOp(3'b100, 32'h0000_0000, 32'h0);
      else Start = 1'b0;
      if (MemReq === 1'b1) reqCycles++;
      nCompared++;
      if (Done !== 1'b0 || MemAddr !== 10'd16 || MemWe !== 1'b0) begin
        nMismatched++;
        $display("FAIL timeout_wait_%0d: got %b/%0d/%b expected 0/16/0", c, Done, MemAddr, MemWe);
      end
      step();
    end
    Start = 1'b0;
    nCompared++;
    if (reqCycles != 15) begin
      nMismatched++;
      $display("FAIL timeout_req_cycles: got %0d expected 15", reqCycles);
    end
    nCompared++;
    if ({MemReq, Done, AddrErr} !== 3'b011 || LoadData !== 32'h0BAD_F00D) begin
      nMismatched++;
      $display("FAIL timeout_done: got %b/%h expected 011/0badf00d", {MemReq, Done, AddrErr},
               LoadData);
    end
    step();
    nCompared++;
    if (Busy !== 1'b0) begin
      nMismatched++;
      $display("FAIL timeout_idle: got %b expected 0", Busy);
    end
  endtask

  task automatic test_reset_mid();
    startOp(3'b001, 32'h0000_0050, 32'h0);
    step();  // cycle 1
    Start = 1'b0;
    step();  // cycle 2
    nCompared++;
    if (MemReq !== 1'b1) begin
      nMismatched++;
      $display("FAIL rstmid_req: got %b expected 1", MemReq);
    end
    rst_n = 1'b0;
    step();  // cycle 3
    rst_n = 1'b1;
    nCompared++;
    if ({MemReq, Busy, Done} !== 3'b000 || LoadData !== 32'h0) begin
      nMismatched++;
      $display("FAIL rstmid_abort: got %b/%h expected 000/00000000", {MemReq, Busy, Done}, LoadData);
    end
    step();  // cycle 4: late ack
    MemRData = 32'h1111_2222;
    MemAck = 1'b1;
    step();  // cycle 5
    MemAck = 1'b0;
    nCompared++;
    if ({MemReq, Busy, Done} !== 3'b000 || LoadData !== 32'h0) begin
      nMismatched++;
      $display("FAIL rstmid_late_ack: got %b/%h expected 000/00000000", {MemReq, Busy, Done},
               LoadData);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    Start = 1'b0;
    MemOp = 3'b000;
    Addr = 32'h0;
    StoreData = 32'h0;
    MemRData = 32'h0;
    MemAck = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_byte_load(3'b011, 32'hFFFF_FF80);
    test_byte_load(3'b010, 32'h0000_0080);
    test_sb();
    test_back_to_back();
    test_faults();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage sitting directly downstream of the ALU: it takes the ALU result as a byte address plus the store operand (register rt data) and performs word/byte loads and stores over a request/acknowledge memory port. It is multi-cycle, holds `Busy` to stall the core while an access is outstanding, and returns aligned, extended load data with a one-cycle `Done` pulse. Alignment, range and bus-timeout faults are reported on `AddrErr` instead of being issued to memory.

## Interface
- `ADDR_W`, 10: data-memory word-address width; valid byte addresses are 0 .. 4·2^ADDR_W−1.
- `TIMEOUT`, 15: max cycles `MemReq` stays high without `MemAck` before the access aborts.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `Start`  in  1  access request; sampled only in IDLE.
- `MemOp`  in  3  000 none, 001 lw, 010 lbu, 011 lb, 100 sw, 101 sb; others treated as none.
- `Addr`  in  32  byte address (ALU `DataOut`).
- `StoreData`  in  32  store operand.
- `Busy`  out  1  high from cycle after accepted `Start` through `Done` cycle inclusive.
- `Done`  out  1  one-cycle completion pulse.
- `LoadData`  out  32  load result; updated only on loads at `Done`, held otherwise.
- `AddrErr`  out  1  fault flag, valid with `Done`, held until next `Done`.
- `MemReq`  out  1  memory request.
- `MemWe`  out  1  write when high.
- `MemAddr`  out  ADDR_W  word address = `Addr[ADDR_W+1:2]`.
- `MemWData`  out  32  write data, byte replicated for sb.
- `MemBe`  out  4  byte enables; 1111 for lw/sw, one-hot on `Addr[1:0]` for byte ops.
- `MemRData`  in  32  read data, valid with `MemAck`.
- `MemAck`  in  1  completion from memory.

## Operation
- States: IDLE, ACCESS, FINISH.
- IDLE: on `Start`, latch `MemOp`, `Addr`, `StoreData`. If op none → FINISH (no request, `AddrErr`=0). If fault → FINISH with `AddrErr`=1, no request. Else → ACCESS.
- Fault = (lw/sw and `Addr[1:0]`≠0) or any nonzero bit in `Addr[31:ADDR_W+2]`.
- ACCESS: `MemReq`=1, `MemAddr/MemWe/MemBe/MemWData` driven from latched values, stable until ack. On `MemAck` → FINISH, capture load data. Timeout counter increments each ACCESS cycle without ack; reaching `TIMEOUT` → FINISH with `AddrErr`=1, `LoadData` unchanged.
- FINISH: `Done`=1 for one cycle → IDLE.
- Load extraction little-endian: byte = `MemRData[8·Addr[1:0]+7 : 8·Addr[1:0]]`; lb sign-extends bit 7, lbu zero-extends; lw passes word.
- sb: `MemWData` = `{4{StoreData[7:0]}}`.
- `Start` while not IDLE ignored. `MemAck` outside ACCESS ignored.
- Reset values: all outputs 0, state IDLE, counter 0, `LoadData`=0.
- Reset asserted mid-access: next edge returns to IDLE, `MemReq`=0, no `Done`; late ack ignored.

## Timing
- `Start` at cycle 0 → `MemReq` high cycle 1. Ack sampled in cycle k (k≥1) → `Done` in cycle k+1. Minimum latency 2 cycles (ack same cycle as first request).
- Op none or fault: `Done` in cycle 1, no request.
- Timeout: `MemReq` high cycles 1..TIMEOUT, `Done` at cycle TIMEOUT+1, `MemReq` low that cycle.
- `Busy` high cycles 1..Done; back-to-back `Start` accepted the cycle after `Done`.
- All outputs registered; no combinational path from `MemAck`/`MemRData` to outputs.

## Structure
- Package `mem_pkg`: `MemOp` encodings, state typedef, default `TIMEOUT`, byte-enable constants.
- Sub-module `mem_load_align`: combinational byte select and sign/zero extension from `MemRData`, `Addr[1:0]`, op.
- Top holds FSM, latches, timeout counter, fault check.

## Test plan
- lw `Addr`=0x0000_0010, `MemRData`=0xDEAD_BEEF, ack cycle 1 → `MemAddr`=4, `MemBe`=1111, `Done` cycle 2, `LoadData`=0xDEAD_BEEF, `AddrErr`=0.
- lb `Addr`=0x13, `MemRData`=0x80FF_1234, ack after 3 cycles → `LoadData`=0xFFFF_FF80; lbu same → 0x0000_0080; `Done` 1 cycle after ack.
- sb `Addr`=0x06, `StoreData`=0x0000_00A5 → `MemWe`=1, `MemBe`=0100, `MemWData`=0xA5A5_A5A5.
- lw `Addr`=0x0000_0002 and sw `Addr`=0x0000_1000 (ADDR_W=10) → no `MemReq`, `Done` cycle 1 with `AddrErr`=1.
- No ack → `MemReq` high exactly 15 cycles, `Done`+`AddrErr` cycle 16, `LoadData` unchanged; `Start` pulses during `Busy` ignored.
- `rst_n` low in cycle 2 of ACCESS → cycle 3 `MemReq`=0, `Busy`=0, no `Done`; ack in cycle 4 ignored.
